led_driver: RTL and testbench

Parametrised multi-channel LED driver for the board's LED bank, running off the on-chip oscillator clock. Each channel has a mode of off, on, blink or PWM dim, selected by switch inputs. A shared blink timebase and a shared PWM counter drive all channels. Per-channel PWM duty values are written through a simple write port. This block replaces fixed-function per-LED logic at the top level.

---
 rtl/led_driver.sv | 125 ++++++++++++
 tb/tb_led_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// led_driver: multi-channel LED driver, each channel off / on / blink / PWM dim.
// One blink timebase and one PWM counter are shared by all channels; duty values arrive via a write strobe.
module led_driver #(
   parameter int  NUM_CH    = 3,
   parameter int  BLINK_DIV = 20_000_000,
   parameter int  PWM_BITS  = 4,
   parameter int  PWM_DIV   = 1024,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2*NUM_CH-1:0]   mode_i,
   input  logic                  duty_we_i,
   input  logic [CH_W-1:0]       duty_ch_i,
   input  logic [PWM_BITS-1:0]   duty_i,
   output logic [NUM_CH-1:0]     led_o,
   output logic                  blink_o
);

   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PWM_DIV - 1);
   localparam logic [PWM_BITS-1:0] DUTY_RST   = PWM_BITS'(1) << (PWM_BITS - 1);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PWM   = 2'b11
   } mode_e;

   logic [2*NUM_CH-1:0]  r_mode_meta;
   logic [2*NUM_CH-1:0]  r_mode_sync;
   logic [BLINK_W-1:0]   r_blink_cnt;
   logic                 r_blink;
   logic [PRE_W-1:0]     r_pwm_pre;
   logic [PWM_BITS-1:0]  r_pwm_cnt;
   logic [PWM_BITS-1:0]  r_duty [NUM_CH];
   logic [NUM_CH-1:0]    r_led;

   logic                 w_blink_wrap;
   logic                 w_pwm_step;
   logic [NUM_CH-1:0]    w_led;

   // Switch inputs are asynchronous; only r_mode_sync is ever decoded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode_meta <= '0;
         r_mode_sync <= '0;
      end else begin
         r_mode_meta <= mode_i;
         r_mode_sync <= r_mode_meta;
      end
   end

   assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
      end else if (w_blink_wrap) begin
         r_blink_cnt <= '0;
         r_blink     <= ~r_blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign w_pwm_step = (r_pwm_pre == PRE_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm_pre <= '0;
         r_pwm_cnt <= '0;
      end else if (w_pwm_step) begin
         r_pwm_pre <= '0;
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end else begin
         r_pwm_pre <= r_pwm_pre + 1'b1;
      end
   end

   // Out-of-range channel indices match no register, so such writes are dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_duty[c] <= DUTY_RST;
         end
      end else if (duty_we_i) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (duty_ch_i == CH_W'(c)) begin
               r_duty[c] <= duty_i;
            end
         end
      end
   end

   always_comb begin
      w_led = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         case (mode_e'(r_mode_sync[2*c +: 2]))
            MODE_OFF:   w_led[c] = 1'b0;
            MODE_ON:    w_led[c] = 1'b1;
            MODE_BLINK: w_led[c] = r_blink;
            MODE_PWM:   w_led[c] = (r_pwm_cnt < r_duty[c]);
            default:    w_led[c] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_led <= '0;
      end else begin
         r_led <= w_led;
      end
   end

   assign led_o   = r_led;
   assign blink_o = r_blink;

endmodule

// File: tb/tb_led_driver.sv
// tb_led_driver: directed bench for led_driver at NUM_CH=3, BLINK_DIV=4, PWM_BITS=2, PWM_DIV=2.
// Edge-indexed expectations are rebuilt from the timebase definitions; key points also use hand constants.
module tb_led_driver;

   localparam int NUM_CH    = 3;
   localparam int BLINK_DIV = 4;
   localparam int PWM_BITS  = 2;
   localparam int PWM_DIV   = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] mode_i;
   logic       duty_we_i;
   logic [1:0] duty_ch_i;
   logic [1:0] duty_i;
   logic [2:0] led_o;
   logic       blink_o;

   int n_checks = 0;
   int n_errors = 0;

   // Bench-side view: edges since reset release, synchroniser stages, duty per channel.
   int         edge_n;
   logic [1:0] p1 [3];
   logic [1:0] p2 [3];
   int         duty_m [3];
   int         hi_cnt [3];

   led_driver #(
      .NUM_CH    (NUM_CH),
      .BLINK_DIV (BLINK_DIV),
      .PWM_BITS  (PWM_BITS),
      .PWM_DIV   (PWM_DIV)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mode_i    (mode_i),
      .duty_we_i (duty_we_i),
      .duty_ch_i (duty_ch_i),
      .duty_i    (duty_i),
      .led_o     (led_o),
      .blink_o   (blink_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // LED level after edge k: pwm_cnt before edge k is ((k-1)/PWM_DIV) mod 4, blink_o before edge k is ((k-1)/BLINK_DIV) mod 2.
   function automatic logic exp_led(input logic [1:0] m, input int d, input int k);
      case (m)
         2'b00:   return 1'b0;
         2'b01:   return 1'b1;
         2'b10:   return (((k - 1) / BLINK_DIV) % 2) == 1;
         default: return (((k - 1) / PWM_DIV) % (1 << PWM_BITS)) < d;
      endcase
   endfunction

   task automatic model_reset();
      edge_n = 0;
      for (int c = 0; c < 3; c++) begin
         p1[c]     = 2'b00;
         p2[c]     = 2'b00;
         duty_m[c] = 2;
      end
   endtask

   // One rising edge, then check led_o and blink_o at the following falling edge.
   task automatic step();
      logic [2:0] e_led;
      logic       e_blink;
      edge_n++;
      for (int c = 0; c < 3; c++) begin
         e_led[c] = exp_led(p2[c], duty_m[c], edge_n);
      end
      e_blink = ((edge_n / BLINK_DIV) % 2) == 1;
      for (int c = 0; c < 3; c++) begin
         p2[c] = p1[c];
         p1[c] = mode_i[2*c +: 2];
      end
      if (duty_we_i && (duty_ch_i < 2'd3)) begin
         duty_m[duty_ch_i] = int'(duty_i);
      end
      @(posedge clk);
      @(negedge clk);
      check("led", 8'(led_o), 8'(e_led));
      check("blink", 8'(blink_o), 8'(e_blink));
      for (int c = 0; c < 3; c++) begin
         hi_cnt[c] += int'(led_o[c]);
      end
   endtask

   task automatic frame(input string tag, input int e0, input int e1, input int e2);
      for (int c = 0; c < 3; c++) hi_cnt[c] = 0;
      repeat (8) step();
      check({tag, "_ch0"}, 8'(hi_cnt[0]), 8'(e0));
      check({tag, "_ch1"}, 8'(hi_cnt[1]), 8'(e1));
      check({tag, "_ch2"}, 8'(hi_cnt[2]), 8'(e2));
   endtask

   // Called at a falling edge; asserts reset between clock edges and checks outputs before any edge.
   task automatic async_reset(input string tag);
      #2 reset_n = 1'b0;
      #1;
      check({tag, "_led"}, 8'(led_o), 8'h00);
      check({tag, "_blink"}, 8'(blink_o), 8'h00);
      model_reset();
      @(negedge clk);
   endtask

   task automatic release_reset();
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic write_duty(input logic [1:0] ch, input logic [1:0] val);
      duty_we_i = 1'b1;
      duty_ch_i = ch;
      duty_i    = val;
      step();
      duty_we_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n   = 1'b0;
      mode_i    = 6'b010101;
      duty_we_i = 1'b0;
      duty_ch_i = 2'd0;
      duty_i    = 2'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_hold_led", 8'(led_o), 8'h00);
      check("reset_hold_blink", 8'(blink_o), 8'h00);

      // Mode latency on ch1
      mode_i = 6'b000100;
      release_reset();
      step(); check("on_lat_e1", 8'(led_o[1]), 8'h00);
      step(); check("on_lat_e2", 8'(led_o[1]), 8'h00);
      step(); check("on_lat_e3", 8'(led_o[1]), 8'h01);
      mode_i = 6'b000000;
      step(); check("off_lat_e1", 8'(led_o[1]), 8'h01);
      step(); check("off_lat_e2", 8'(led_o[1]), 8'h01);
      step(); check("off_lat_e3", 8'(led_o[1]), 8'h00);
      mode_i = 6'b000100;
      repeat (6) step();
      check("pre_areset_led", 8'(led_o), 8'h02);
      check("pre_areset_blink", 8'(blink_o), 8'h01);
      async_reset("areset1");

      // Blink on ch0
      mode_i = 6'b000010;
      @(negedge clk);
      release_reset();
      for (int k = 1; k <= 13; k++) begin
         step();
         if (k == 3) check("blink_e3", 8'(blink_o), 8'h00);
         if (k == 4) check("blink_first_high", 8'(blink_o), 8'h01);
         if (k == 4) check("blink_led_e4", 8'(led_o[0]), 8'h00);
         if (k == 5) check("blink_led_e5", 8'(led_o[0]), 8'h01);
         if (k == 8) check("blink_low_e8", 8'(blink_o), 8'h00);
         if (k == 9) check("blink_led_e9", 8'(led_o[0]), 8'h00);
      end
      check("blink_led_e13", 8'(led_o[0]), 8'h01);
      async_reset("areset2");

      // PWM duty sweep on ch2
      mode_i = 6'b110000;
      release_reset();
      step();
      step();
      frame("duty2", 0, 0, 4);
      write_duty(2'd2, 2'd1);
      frame("duty1", 0, 0, 2);
      write_duty(2'd2, 2'd3);
      frame("duty3", 0, 0, 6);
      write_duty(2'd2, 2'd0);
      frame("duty0", 0, 0, 0);

      // Out-of-range duty write
      mode_i = 6'b111111;
      repeat (3) step();
      frame("allpwm", 4, 4, 0);
      write_duty(2'd3, 2'd3);
      frame("oor_write", 4, 4, 0);

      // Mixed modes, then duty returns to reset value
      mode_i = 6'b110100;
      write_duty(2'd2, 2'd1);
      repeat (2) step();
      frame("mixed", 0, 8, 2);
      async_reset("areset3");
      release_reset();
      step();
      step();
      frame("duty_after_reset", 0, 8, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
